// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
//
// Contents:
//   FETCH_BUF_DEPTH   number of fetched words held between imem and decode
//   DEFAULT_RESET_PC  first fetch address after reset
//   fetch_state_t     REQ (may request), WAIT (live response due), DROP (stale response due)
//   fetch_entry_t     one buffered fetch: granted address plus returned word
package fetch_pkg;

  localparam int unsigned FETCH_BUF_DEPTH  = 2;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_1000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - two-entry FIFO of fetched words between imem and decode
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   flush        empty the FIFO; wins over push and pop in the same cycle
//   push         write push_entry at the tail
//   push_entry   fetched word with its granted address
//   pop          drop the head entry (caller only pops when count != 0)
//   count        number of valid entries, 0..2
//   head         oldest entry
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [FETCH_BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the count unchanged.
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with single-outstanding imem handshake
//
// Parameters:
//   RESET_PC        first fetch address after reset (bits [1:0] zero)
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   redirect_valid  redirect the fetch stream to redirect_pc (bits [1:0] ignored)
//   imem_req/imem_addr/imem_gnt            request side of the imem port
//   imem_rvalid/imem_rdata                 in-order response side, one per grant
//   inst_valid/inst/pc/inst_ready          head of the fetch buffer toward decode
// Build option:
//   FETCH_TRACE_EN  print popped and dropped fetches; the trace build must make
//                   check_verbose() from isa.vh visible to this module.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] pc,
  input  logic        inst_ready
);

  fetch_state_t state;
  logic [63:0]  fetch_pc;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         buf_push;
  logic         buf_pop;
  logic         has_room;
  logic         unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Requests stop once both slots are committed, so a push never meets a full buffer.
  assign has_room   = count < 2'(FETCH_BUF_DEPTH);
  assign imem_req   = ~rst & (state == REQ) & has_room & ~redirect_valid;
  assign imem_addr  = fetch_pc;

  assign inst_valid = ~rst & (count != 2'd0) & ~redirect_valid;
  assign inst       = rst ? 32'd0 : head.inst;
  assign pc         = rst ? 64'd0 : head.pc;

  // fetch_pc already advanced past the granted address when the grant was taken.
  assign push_entry = '{pc: fetch_pc - 64'd4, inst: imem_rdata};
  assign buf_push   = (state == WAIT) & imem_rvalid & ~redirect_valid;
  assign buf_pop    = inst_valid & inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[63:2], 2'b00};
      // A response still owed after this cycle must be swallowed before requesting again.
      state    <= ((state != REQ) && !imem_rvalid) ? DROP : REQ;
    end else begin
      unique case (state)
        REQ: begin
          if (imem_req && imem_gnt) begin
            fetch_pc <= fetch_pc + 64'd4;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) state <= REQ;
        end
        DROP: begin
          if (imem_rvalid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (buf_push),
    .push_entry (push_entry),
    .pop        (buf_pop),
    .count      (count),
    .head       (head)
  );

`ifdef FETCH_TRACE_EN
  // Once redirected, fetch_pc no longer holds the abandoned address, so keep a copy.
  logic [63:0] trace_drop_addr;

  always @(posedge clk) begin
    if (!rst) begin
      if (redirect_valid && state == WAIT && !imem_rvalid) begin
        trace_drop_addr <= fetch_pc - 64'd4;
      end
      if (buf_pop && check_verbose(pc)) begin
        $display("%0t Fetch: [%08h] %h", $time, pc[31:0], inst);
      end
      if (imem_rvalid && state == WAIT && redirect_valid) begin
        $display("%0t Fetch drop: [%08h]", $time, fetch_pc[31:0] - 32'd4);
      end
      if (imem_rvalid && state == DROP) begin
        $display("%0t Fetch drop: [%08h]", $time, trace_drop_addr[31:0]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with a transaction-level model
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        inst_ready;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_gnt;
  logic        w_rvalid;
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [63:0] w_pc;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .pc             (pc),
    .inst_ready     (inst_ready)
  );

  fetch_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (1'b0),
    .redirect_pc    (64'd0),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_gnt       (w_gnt),
    .imem_rvalid    (w_rvalid),
    .imem_rdata     (32'd0),
    .inst_valid     (w_inst_valid),
    .inst           (w_inst),
    .pc             (w_pc),
    .inst_ready     (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  // Model: words owed to decode, next address the stream should request, one outstanding grant.
  exp_t        q[$];
  logic [63:0] exp_next;
  bit          out_busy;
  bit          out_live;
  logic [63:0] out_addr;
  int          out_wait;
  logic [63:0] grant_log[$];
  exp_t        pop_log[$];
  int          pop_cyc[$];
  int          cyc;
  int          checks;
  int          errors;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_next = 64'h1000;
    out_busy = 0;
    out_live = 0;
    out_wait = 0;
    grant_log.delete();
    pop_log.delete();
    pop_cyc.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready = 1'b0;
    w_gnt = 1'b0;
    w_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive at the negedge, check combinational outputs, advance the model at posedge.
  task automatic cycle(input bit redir, input logic [63:0] rpc, input bit gnt, input bit rdy, input int lat);
    bit   rv;
    bit   exp_req;
    bit   exp_vld;
    exp_t e;
    rv = out_busy && (out_wait == 0);
    redirect_valid = redir;
    redirect_pc = rpc;
    imem_gnt = gnt;
    inst_ready = rdy;
    imem_rvalid = rv;
    imem_rdata = rv ? (out_live ? mem_word(out_addr) : 32'hDEAD_BEEF) : $urandom;
    #1;
    exp_req = !redir && !out_busy && (q.size() < 2);
    exp_vld = !redir && (q.size() != 0);
    checks++;
    if (imem_req !== exp_req) begin
      errors++;
      $display("FAIL imem_req cyc %0d got %b exp %b", cyc, imem_req, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (imem_addr !== exp_next) begin
        errors++;
        $display("FAIL imem_addr cyc %0d got %h exp %h", cyc, imem_addr, exp_next);
      end
    end
    checks++;
    if (inst_valid !== exp_vld) begin
      errors++;
      $display("FAIL inst_valid cyc %0d got %b exp %b", cyc, inst_valid, exp_vld);
    end
    if (exp_vld) begin
      checks++;
      if (pc !== q[0].pc || inst !== q[0].inst) begin
        errors++;
        $display("FAIL head cyc %0d got %h/%h exp %h/%h", cyc, pc, inst, q[0].pc, q[0].inst);
      end
    end
    if (imem_req === 1'b1 && gnt) grant_log.push_back(imem_addr);
    if (inst_valid === 1'b1 && rdy) begin
      e.pc = pc;
      e.inst = inst;
      pop_log.push_back(e);
      pop_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (out_busy && !rv && out_wait > 0) out_wait--;
    if (redir) begin
      q.delete();
      exp_next = {rpc[63:2], 2'b00};
      out_live = 0;
    end else if (exp_vld && rdy) begin
      void'(q.pop_front());
    end
    if (rv) begin
      if (out_live) begin
        e.pc = out_addr;
        e.inst = mem_word(out_addr);
        q.push_back(e);
      end
      out_busy = 0;
    end
    if (exp_req && gnt) begin
      out_busy = 1;
      out_live = 1;
      out_addr = exp_next;
      out_wait = lat;
      exp_next = exp_next + 64'd4;
    end
    cyc++;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_gnt = 1'b1;
    inst_ready = 1'b1;
    w_gnt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    checks++;
    if (inst !== 32'd0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst); end
    checks++;
    if (pc !== 64'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
    checks++;
    if (w_req !== 1'b0) begin errors++; $display("FAIL reset_w_req got %b exp 0", w_req); end
    imem_gnt = 1'b0;
    w_gnt = 1'b0;
    inst_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin
      errors++;
      $display("FAIL first_req got %b/%h exp 1/%h", imem_req, imem_addr, 64'h1000);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 64'd0, 1'b1, 1'b1, 0);
    checks++;
    if (grant_log.size() < 3) begin
      errors++;
      $display("FAIL stream_grants got %0d exp >=3", grant_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (grant_log[i] !== 64'h1000 + 64'(4 * i)) begin
          errors++;
          $display("FAIL stream_addr%0d got %h exp %h", i, grant_log[i], 64'h1000 + 64'(4 * i));
        end
      end
    end
    checks++;
    if (pop_log.size() != 3) begin
      errors++;
      $display("FAIL stream_pops got %0d exp 3", pop_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pop_cyc[i] != 2 + 2 * i || pop_log[i].pc !== 64'h1000 + 64'(4 * i)
            || pop_log[i].inst !== mem_word(64'h1000 + 64'(4 * i))) begin
          errors++;
          $display("FAIL stream_pop%0d got cyc %0d pc %h inst %h exp cyc %0d pc %h", i, pop_cyc[i],
                   pop_log[i].pc, pop_log[i].inst, 2 + 2 * i, 64'h1000 + 64'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0, 0);
    checks++;
    if (grant_log.size() != 2) begin
      errors++;
      $display("FAIL bp_grants got %0d exp 2", grant_log.size());
    end
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req got %b exp 0", imem_req); end
    cycle(1'b0, 64'd0, 1'b0, 1'b1, 0);
    checks++;
    if (pop_log.size() != 1 || pop_log[0].pc !== 64'h1000) begin
      errors++;
      $display("FAIL bp_pop got %0d entries exp pc %h", pop_log.size(), 64'h1000);
    end
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h1008) begin
      errors++;
      $display("FAIL bp_resume got %b/%h exp 1/%h", imem_req, imem_addr, 64'h1008);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 64'd0, 1'b1, 1'b1, 1);
  endtask

  task automatic test_redirect_wait();
    do_reset();
    cycle(1'b0, 64'd0, 1'b1, 1'b1, 3);
    cycle(1'b1, 64'h2002, 1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b0, 1'b1, 0);
    checks++;
    if (pop_log.size() != 0) begin
      errors++;
      $display("FAIL rw_delivered got %0d exp 0", pop_log.size());
    end
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h2000 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_next got %b/%h/%b exp 1/%h/0", imem_req, imem_addr, inst_valid, 64'h2000);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b1, 1'b1, 0);
    checks++;
    if (pop_log.size() < 1 || pop_log[0].pc !== 64'h2000) begin
      errors++;
      $display("FAIL rw_first_pop got %0d entries exp pc %h", pop_log.size(), 64'h2000);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    cycle(1'b0, 64'd0, 1'b1, 1'b1, 0);
    cycle(1'b1, 64'h3000, 1'b0, 1'b1, 0);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h3000 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_next got %b/%h/%b exp 1/%h/0", imem_req, imem_addr, inst_valid, 64'h3000);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b1, 1'b1, 0);
    checks++;
    if (pop_log.size() != 1 || pop_log[0].pc !== 64'h3000) begin
      errors++;
      $display("FAIL rr_pop got %0d entries exp one at %h", pop_log.size(), 64'h3000);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    w_gnt = 1'b1;
    #1;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first got %b/%h exp 1/%h", w_req, w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    end
    @(posedge clk);
    @(negedge clk);
    w_gnt = 1'b0;
    w_rvalid = 1'b1;
    #1;
    checks++;
    if (w_req !== 1'b0) begin errors++; $display("FAIL wrap_wait_req got %b exp 0", w_req); end
    @(posedge clk);
    @(negedge clk);
    w_rvalid = 1'b0;
    #1;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 64'd0) begin
      errors++;
      $display("FAIL wrap_second got %b/%h exp 1/0", w_req, w_addr);
    end
    checks++;
    if (w_inst_valid !== 1'b1 || w_pc !== 64'hFFFF_FFFF_FFFF_FFFC || w_inst !== 32'd0) begin
      errors++;
      $display("FAIL wrap_head got %b/%h/%h exp 1/%h/0", w_inst_valid, w_pc, w_inst, 64'hFFFF_FFFF_FFFF_FFFC);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b0, 64'd0, 1'b1, 1'b0, 0);
    cycle(1'b0, 64'd0, 1'b0, 1'b0, 0);
    cycle(1'b0, 64'd0, 1'b1, 1'b0, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got valid %b req %b exp 0/0", inst_valid, imem_req);
    end
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h1000 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release got %b/%h/%b exp 1/%h/0", imem_req, imem_addr, inst_valid, 64'h1000);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 64'd0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      logic [63:0] rp;
      r = ($urandom_range(0, 15) == 0);
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rp[63:4] = '1;
      cycle(r, rp, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'd0;
    inst_ready = 1'b0;
    w_gnt = 1'b0;
    w_rvalid = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the PC/redirect logic and the instruction memory port. It generates sequential fetch addresses and runs a single-outstanding request/grant/response handshake with imem. Returned words are queued with their PC in a 2-entry buffer, and the buffer drives `inst`/`pc` to decode over a valid/ready handshake. Branch and trap redirects flush the buffer and discard any in-flight response.

## Interface
- `RESET_PC`, default 64'h0000_0000_0000_1000: first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `redirect_valid`  in  1  redirect fetch stream this cycle.
- `redirect_pc`  in  64  new fetch address; bits [1:0] ignored (treated as 0).
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  64  fetch address; valid while `imem_req`=1.
- `imem_gnt`  in  1  request accepted this cycle (only meaningful with `imem_req`=1).
- `imem_rvalid`  in  1  response data valid; earliest the cycle after gnt; in order; exactly one per grant.
- `imem_rdata`  in  32  instruction word.
- `inst_valid`  out  1  buffer head valid.
- `inst`  out  32  head instruction.
- `pc`  out  64  head PC.
- `inst_ready`  in  1  decode accepts head.

## Operation
- Registers: `fetch_pc` (64 b), `state`, 2-entry buffer with count 0..2.
- The `RESET` state exists only while `rst`=1. Reset values:
  - `state`=REQ, `fetch_pc`=`RESET_PC`, count=0.
  - `imem_req`=0 and `inst_valid`=0 during reset; `inst`/`pc` outputs are 0.
- REQ state:
  - `imem_req` = (count<2) & ~`redirect_valid`; `imem_addr`=`fetch_pc`.
  - On `imem_gnt`: `fetch_pc`+=4, go to WAIT.
  - The address may change while ungranted; imem samples only on gnt.
- WAIT state:
  - `imem_req`=0.
  - On `imem_rvalid`: push {`fetch_pc`−4, `imem_rdata`}, go to REQ.
- DROP state:
  - `imem_req`=0.
  - On `imem_rvalid`: discard the data, go to REQ.
- Redirect (highest priority, any state):
  - Buffer flushed (count=0); `fetch_pc`=`{redirect_pc[63:2],2'b00}`.
  - State becomes DROP if a response is outstanding after this cycle: state WAIT without `imem_rvalid` this cycle, or already DROP without `imem_rvalid` this cycle. Otherwise state becomes REQ.
  - No gnt can occur on a redirect cycle, because `imem_req` is gated.
  - A response arriving in the redirect cycle is discarded.
- Buffer:
  - `inst_valid` = (count≠0) & ~`redirect_valid`.
  - A pop occurs on `inst_valid` & `inst_ready`.
  - Push and pop in the same cycle is allowed; count is unchanged.
  - A push at count=2 cannot occur, because requests are issued only when count<2.
- `fetch_pc` wraps modulo 2^64, with no error.
- `pc` for each buffered entry is the address actually granted.

## Timing
- First `imem_req` is in the first cycle with `rst`=0, with `imem_addr`=`RESET_PC`.
- Gnt at cycle t → earliest `imem_rvalid` at t+1 → `inst_valid` at t+2.
- Peak throughput is 1 instruction per 2 cycles (REQ, WAIT).
- Redirect at cycle t:
  - `inst_valid`=0 at t.
  - Request to `redirect_pc` at t+1 if nothing is outstanding.
  - Otherwise the request follows in the cycle after the dropped `rvalid`.
- `rst` asserted mid-transaction: any later `imem_rvalid` for the abandoned grant is the memory's responsibility; it is reset together with fetch_ctrl.

## Configuration
- `FETCH_TRACE_EN` defined:
  - On every buffer pop, print a simulation line: time, "Fetch: [pc] inst" (pc 8 hex digits, inst hex).
  - Only when `check_verbose(pc)` from isa.vh is true.
  - Dropped responses print "Fetch drop: [addr]".
- Not defined: no display code; RTL and behaviour otherwise identical.

## Structure
- `fetch_pkg` contains:
  - `fetch_state_t` enum {REQ, WAIT, DROP}.
  - `fetch_entry_t` struct {logic [63:0] pc; logic [31:0] inst;}.
  - `FETCH_BUF_DEPTH`=2.
  - `DEFAULT_RESET_PC`.
- Sub-module `fetch_buf`: 2-entry FIFO of `fetch_entry_t` with push, pop, flush, count, head.
  - Flush has priority over push and pop.

## Test plan
- Reset release, `imem_gnt`=1 every cycle, `imem_rvalid` one cycle after each gnt, `inst_ready`=1 → addresses 0x1000, 0x1004, 0x1008 requested; the pc/inst pairs come out in order, one every 2 cycles.
- `inst_ready`=0 → exactly 2 entries buffered, then `imem_req` stays 0. Raise `inst_ready` → head pc=0x1000 popped, a new request issued next cycle.
- Redirect to 0x2002 during WAIT; `rvalid` 3 cycles later with 0xDEADBEEF → word not delivered; next request address 0x2000; buffer empty.
- Redirect in the same cycle as `imem_rvalid` in WAIT → data dropped, state REQ, request to the new PC on the next cycle.
- `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC → second request address 0x0 (wrap).
- `rst` asserted in WAIT with count=1 → next cycle `inst_valid`=0, `imem_req`=0; after release the request goes to `RESET_PC`.
